regfile_mp: RTL and testbench

- Parametrised multi-port general-purpose register file; successor to the single-write, two-read regfile.
- Sits between decode (read ports, issue) and writeback (two write ports, e.g. dual-issue or a load return beside ALU writeback).
- Adds a per-register busy scoreboard so decode can detect RAW hazards against in-flight producers.
- Adds a registered count of outstanding producers.

---
 rtl/regfile_mp.sv | 134 +++++++++++++
 tb/tb_regfile_mp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module  : regfile_mp
// Brief   : Multi-port register file (NRD reads, 2 writes) with per-register
//           busy scoreboard; optional same-cycle bypass via REGFILE_MP_BYPASS_EN.
// Rev     : 1.0
// ============================================================================
module regfile_mp #(
   parameter int DW  = 32,
   parameter int AW  = 5,
   parameter int NRD = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NRD-1:0]    ren,
   input  logic [NRD*AW-1:0] raddr,
   output logic [NRD*DW-1:0] rdata,
   output logic [NRD-1:0]    rbusy,
   input  logic              we0,
   input  logic [AW-1:0]     waddr0,
   input  logic [DW-1:0]     wdata0,
   input  logic              we1,
   input  logic [AW-1:0]     waddr1,
   input  logic [DW-1:0]     wdata1,
   input  logic              iss_v,
   input  logic [AW-1:0]     iss_addr,
   output logic [AW:0]       busy_cnt
);

   localparam int c_DEPTH = 2**AW;

   logic [DW-1:0]      r_mem [c_DEPTH];
   logic [c_DEPTH-1:0] r_busy;
   logic [AW:0]        r_busy_cnt;

   logic [c_DEPTH-1:0] w_busy_nxt;
   logic               w_set_inc;
   logic               w_clr0;
   logic               w_clr1;
   logic               w_iss_ok;

   assign w_iss_ok = iss_v && (iss_addr != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < c_DEPTH; r++) begin
            r_mem[r] <= '0;
         end
      end else begin
         for (int r = 1; r < c_DEPTH; r++) begin
            if (we1 && (waddr1 == AW'(r))) begin
               r_mem[r] <= wdata1;
            end else if (we0 && (waddr0 == AW'(r))) begin
               r_mem[r] <= wdata0;
            end
         end
      end
   end

   // A new producer supersedes a retiring one on the same register.
   always_comb begin
      w_busy_nxt = '0;
      for (int r = 1; r < c_DEPTH; r++) begin
         if (iss_v && (iss_addr == AW'(r))) begin
            w_busy_nxt[r] = 1'b1;
         end else if ((we0 && (waddr0 == AW'(r))) || (we1 && (waddr1 == AW'(r)))) begin
            w_busy_nxt[r] = 1'b0;
         end else begin
            w_busy_nxt[r] = r_busy[r];
         end
      end
   end

   // Incremental count: a clear only counts once per distinct busy register
   // and never on the register being reissued.
   assign w_set_inc = w_iss_ok && !r_busy[iss_addr];
   assign w_clr0    = we0 && (waddr0 != '0) && r_busy[waddr0]
                      && !(iss_v && (iss_addr == waddr0));
   assign w_clr1    = we1 && (waddr1 != '0) && r_busy[waddr1]
                      && !(iss_v && (iss_addr == waddr1))
                      && !(we0 && (waddr0 == waddr1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= r_busy_cnt + (AW+1)'(w_set_inc)
                       - (AW+1)'(w_clr0) - (AW+1)'(w_clr1);
      end
   end

   assign busy_cnt = r_busy_cnt;

   generate
      for (genvar i = 0; i < NRD; i++) begin : g_rd
         logic [AW-1:0] w_ra;
         logic          w_hit0;
         logic          w_hit1;
         logic [DW-1:0] w_rd;
         logic          w_rb;

         assign w_ra = raddr[i*AW +: AW];
`ifdef REGFILE_MP_BYPASS_EN
         assign w_hit1 = we1 && (waddr1 == w_ra);
         assign w_hit0 = we0 && (waddr0 == w_ra);
`else
         assign w_hit1 = 1'b0;
         assign w_hit0 = 1'b0;
`endif

         always_comb begin
            w_rd = '0;
            w_rb = 1'b0;
            if (!rst && ren[i] && (w_ra != '0)) begin
               if (w_hit1) begin
                  w_rd = wdata1;
               end else if (w_hit0) begin
                  w_rd = wdata0;
               end else begin
                  w_rd = r_mem[w_ra];
               end
               w_rb = r_busy[w_ra] && !(w_hit0 || w_hit1);
            end
         end

         assign rdata[i*DW +: DW] = w_rd;
         assign rbusy[i]          = w_rb;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_mp
// Brief   : Directed self-checking bench for regfile_mp (honours REGFILE_MP_BYPASS_EN).
// Rev     : 1.0
// ============================================================================
module tb_regfile_mp;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int NRD = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NRD-1:0]    ren;
   logic [NRD*AW-1:0] raddr;
   logic [NRD*DW-1:0] rdata;
   logic [NRD-1:0]    rbusy;
   logic              we0, we1, iss_v;
   logic [AW-1:0]     waddr0, waddr1, iss_addr;
   logic [DW-1:0]     wdata0, wdata1;
   logic [AW:0]       busy_cnt;

   int n_vec = 0;
   int n_err = 0;

   regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
      .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .rdata(rdata),
      .rbusy(rbusy), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .iss_v(iss_v),
      .iss_addr(iss_addr), .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic idle();
      we0 = 1'b0; waddr0 = '0; wdata0 = '0;
      we1 = 1'b0; waddr1 = '0; wdata1 = '0;
      iss_v = 1'b0; iss_addr = '0;
      ren = '0; raddr = '0;
   endtask

   task automatic rd(input int p, input logic [AW-1:0] a);
      ren[p] = 1'b1;
      raddr[p*AW +: AW] = a;
   endtask

   // Clock edge, then settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      check_eq("rst_cnt", busy_cnt, 0);
      rd(0, 5'd5);
      #1;
      check_eq("rst_rdata", rdata[0 +: DW], 0);
      check_eq("rst_rbusy", rbusy, 0);

      // Preload r5 and mark it busy, then reset
      idle();
      we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1234;
      iss_v = 1'b1; iss_addr = 5'd5;
      step();
      idle();
      rd(0, 5'd5);
      #1;
      check_eq("pre_r5", rdata[0 +: DW], 32'h1234);
      check_eq("pre_cnt", busy_cnt, 1);
      check_eq("pre_busy", rbusy[0], 1);
      rst = 1'b1;
      #1;
      check_eq("inrst_rdata", rdata[0 +: DW], 0);
      check_eq("inrst_rbusy", rbusy, 0);
      step();
      rst = 1'b0;
      #1;
      check_eq("post_r5", rdata[0 +: DW], 0);
      check_eq("post_cnt", busy_cnt, 0);
      check_eq("post_rbusy", rbusy, 0);

      // Register zero ignores writes and issues
      idle();
      we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
      iss_v = 1'b1; iss_addr = 5'd0;
      rd(0, 5'd0);
      #1;
      check_eq("r0_comb", rdata[0 +: DW], 0);
      step();
      idle();
      rd(0, 5'd0);
      #1;
      check_eq("r0_rdata", rdata[0 +: DW], 0);
      check_eq("r0_rbusy", rbusy[0], 0);
      check_eq("r0_cnt", busy_cnt, 0);

      // Dual-write collision: port 1 wins
      idle();
      we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hAAAA;
      we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h5555;
      step();
      idle();
      rd(1, 5'd7);
      #1;
      check_eq("coll_r7", rdata[DW +: DW], 32'h5555);
      ren = '0;
      #1;
      check_eq("ren_off", rdata[DW +: DW], 0);

      // Bypass: r3=0x10 busy, same-cycle write 0x20
      idle();
      we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h10;
      step();
      idle();
      iss_v = 1'b1; iss_addr = 5'd3;
      step();
      idle();
      we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h20;
      rd(1, 5'd3);
      #1;
`ifdef REGFILE_MP_BYPASS_EN
      check_eq("byp_rdata", rdata[DW +: DW], 32'h20);
      check_eq("byp_rbusy", rbusy[1], 0);
`else
      check_eq("byp_rdata", rdata[DW +: DW], 32'h10);
      check_eq("byp_rbusy", rbusy[1], 1);
`endif
      step();
      idle();
      rd(1, 5'd3);
      #1;
      check_eq("byp_after", rdata[DW +: DW], 32'h20);
      check_eq("byp_clr", rbusy[1], 0);
      check_eq("byp_cnt", busy_cnt, 0);
      we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h30;
      we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h40;
      #1;
`ifdef REGFILE_MP_BYPASS_EN
      check_eq("byp_prio", rdata[DW +: DW], 32'h40);
`else
      check_eq("byp_prio", rdata[DW +: DW], 32'h20);
`endif
      step();

      // Scoreboard on r9
      idle();
      iss_v = 1'b1; iss_addr = 5'd9;
      step();
      idle();
      rd(0, 5'd9);
      #1;
      check_eq("sb_busy1", rbusy[0], 1);
      check_eq("sb_cnt1", busy_cnt, 1);
      iss_v = 1'b1; iss_addr = 5'd9;
      we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99;
      step();
      idle();
      rd(0, 5'd9);
      #1;
      check_eq("sb_busy2", rbusy[0], 1);
      check_eq("sb_cnt2", busy_cnt, 1);
      check_eq("sb_data2", rdata[0 +: DW], 32'h99);
      we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h9A;
      step();
      idle();
      rd(0, 5'd9);
      #1;
      check_eq("sb_busy3", rbusy[0], 0);
      check_eq("sb_cnt3", busy_cnt, 0);

      // Count: r1,r2,r3 then retire r1,r2 with issue r4
      for (int k = 1; k <= 3; k++) begin
         idle();
         iss_v = 1'b1; iss_addr = AW'(k);
         step();
      end
      idle();
      #1;
      check_eq("cnt_3", busy_cnt, 3);
      we0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'h1;
      we1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h2;
      iss_v = 1'b1; iss_addr = 5'd4;
      step();
      idle();
      rd(0, 5'd3);
      rd(1, 5'd4);
      #1;
      check_eq("cnt_2", busy_cnt, 2);
      check_eq("cnt_busy34", rbusy, 2'b11);
      raddr[0 +: AW] = 5'd1;
      #1;
      check_eq("cnt_r1_clr", rbusy[0], 0);

      // Double retire in one cycle
      idle();
      we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h3;
      we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h4;
      step();
      idle();
      #1;
      check_eq("cnt_0", busy_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
